// File: rtl/instr_dispatch_pkg.sv
// Shared types for the instruction dispatcher: instruction-type encodings,
// payload widths, queue entry layout and dispatcher FSM states.
package instr_dispatch_pkg;

    localparam logic [1:0] INSTR_TYPE_RAM   = 2'd0;
    localparam logic [1:0] INSTR_TYPE_LD_ST = 2'd1;
    localparam logic [1:0] INSTR_TYPE_ARITH = 2'd2;
    localparam logic [1:0] INSTR_TYPE_LOOP  = 2'd3;

    localparam int ARITH_W = 9;
    localparam int RAM_W   = 3;
    localparam int LDST_W  = 7;
    localparam int ADDR_W  = 18;
    localparam int STALL_W = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } dispatch_state_t;

    typedef struct packed {
        logic [1:0]         itype;
        logic [ARITH_W-1:0] arith;
        logic [RAM_W-1:0]   ram;
        logic [LDST_W-1:0]  ldst;
        logic [ADDR_W-1:0]  cache_addr;
        logic [ADDR_W-1:0]  main_addr;
    } dispatch_entry_t;

    localparam int ENTRY_W = $bits(dispatch_entry_t);

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == {STALL_W{1'b1}}) ? v : v + {{(STALL_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Circular instruction queue; head entry is read combinationally.
// Push is ignored when full and pop is ignored when empty.
module dispatch_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_dat;
    end

    assign head_dat = r_mem[r_rd_ptr];
    assign full     = (r_count == CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;

endmodule

// File: rtl/instr_dispatch.sv
// In-order dispatcher: routes the queue head to the RAM, load/store or arithmetic unit.
// Optional per-unit stall counters are enabled by macro DISPATCH_STALL_CNT_EN.
module instr_dispatch
    import instr_dispatch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    queue_we,
    input  logic [1:0]              queue_instr_type,
    input  logic [ARITH_W-1:0]      queue_arith_instr,
    input  logic [RAM_W-1:0]        queue_ram_instr,
    input  logic [LDST_W-1:0]       queue_ld_st_instr,
    input  logic [ADDR_W-1:0]       cache_addr,
    input  logic [ADDR_W-1:0]       main_mem_addr,
    input  logic                    program_complete,
    output logic                    queue_full,
    output logic [$clog2(DEPTH):0]  queue_count,
    output logic                    ram_valid,
    input  logic                    ram_ready,
    output logic [RAM_W-1:0]        ram_instr,
    output logic [ADDR_W-1:0]       ram_cache_addr,
    output logic [ADDR_W-1:0]       ram_main_mem_addr,
    output logic                    ldst_valid,
    input  logic                    ldst_ready,
    output logic [LDST_W-1:0]       ldst_instr,
    output logic [ADDR_W-1:0]       ldst_cache_addr,
    output logic                    arith_valid,
    input  logic                    arith_ready,
    output logic [ARITH_W-1:0]      arith_instr,
    output logic                    all_done,
    output logic                    dispatch_error,
    output logic [STALL_W-1:0]      ram_stall_cnt,
    output logic [STALL_W-1:0]      ldst_stall_cnt,
    output logic [STALL_W-1:0]      arith_stall_cnt
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    dispatch_entry_t  w_push_entry;
    dispatch_entry_t  w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_is_loop;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_nxt;
    dispatch_state_t  r_state;
    dispatch_state_t  w_state_nxt;
    logic             r_error;

    assign w_push_entry = '{itype:      queue_instr_type,
                            arith:      queue_arith_instr,
                            ram:        queue_ram_instr,
                            ldst:       queue_ld_st_instr,
                            cache_addr: cache_addr,
                            main_addr:  main_mem_addr};

    assign w_is_loop = (queue_instr_type == INSTR_TYPE_LOOP);
    assign w_push    = queue_we & ~w_full & ~w_is_loop;

    dispatch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_push),
        .push_dat (w_push_entry),
        .pop      (w_pop),
        .head_dat (w_head),
        .full     (w_full),
        .empty    (w_empty),
        .count    (w_count)
    );

    assign ram_valid   = ~w_empty & (w_head.itype == INSTR_TYPE_RAM);
    assign ldst_valid  = ~w_empty & (w_head.itype == INSTR_TYPE_LD_ST);
    assign arith_valid = ~w_empty & (w_head.itype == INSTR_TYPE_ARITH);

    // Payloads are zeroed off their own valid so idle ports never show stale storage.
    assign ram_instr         = ram_valid   ? w_head.ram        : '0;
    assign ram_cache_addr    = ram_valid   ? w_head.cache_addr : '0;
    assign ram_main_mem_addr = ram_valid   ? w_head.main_addr  : '0;
    assign ldst_instr        = ldst_valid  ? w_head.ldst       : '0;
    assign ldst_cache_addr   = ldst_valid  ? w_head.cache_addr : '0;
    assign arith_instr       = arith_valid ? w_head.arith      : '0;

    assign w_pop = (ram_valid & ram_ready) | (ldst_valid & ldst_ready) |
                   (arith_valid & arith_ready);

    assign w_count_nxt = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_RUN;
        else       r_state <= w_state_nxt;
    end

    // DRAIN also completes on an already-empty queue, giving the two-cycle done path.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (program_complete)    w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_count_nxt == '0)   w_state_nxt = ST_DONE;
            ST_DONE:  if (w_push)              w_state_nxt = ST_RUN;
            default:                           w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                r_error <= 1'b0;
        else if (queue_we & (w_full | w_is_loop)) r_error <= 1'b1;
    end

    assign queue_full     = w_full;
    assign queue_count    = w_count;
    assign all_done       = (r_state == ST_DONE);
    assign dispatch_error = r_error;

`ifdef DISPATCH_STALL_CNT_EN
    logic [STALL_W-1:0] r_ram_stall;
    logic [STALL_W-1:0] r_ldst_stall;
    logic [STALL_W-1:0] r_arith_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ram_stall   <= '0;
            r_ldst_stall  <= '0;
            r_arith_stall <= '0;
        end else begin
            if (ram_valid & ~ram_ready)     r_ram_stall   <= sat_inc(r_ram_stall);
            if (ldst_valid & ~ldst_ready)   r_ldst_stall  <= sat_inc(r_ldst_stall);
            if (arith_valid & ~arith_ready) r_arith_stall <= sat_inc(r_arith_stall);
        end
    end

    assign ram_stall_cnt   = r_ram_stall;
    assign ldst_stall_cnt  = r_ldst_stall;
    assign arith_stall_cnt = r_arith_stall;
`else
    assign ram_stall_cnt   = '0;
    assign ldst_stall_cnt  = '0;
    assign arith_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_dispatch.sv
// Self-checking bench for instr_dispatch: vector table plus directed multi-cycle sequences.
module tb_instr_dispatch;
    import instr_dispatch_pkg::*;

    localparam int DEPTH = 8;
    localparam logic [1:0] T_R = INSTR_TYPE_RAM;
    localparam logic [1:0] T_L = INSTR_TYPE_LD_ST;
    localparam logic [1:0] T_A = INSTR_TYPE_ARITH;
    localparam logic [1:0] T_P = INSTR_TYPE_LOOP;
`ifdef DISPATCH_STALL_CNT_EN
    localparam logic [15:0] STALL_EXP = 16'd5;
`else
    localparam logic [15:0] STALL_EXP = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        queue_we;
    logic [1:0]  queue_instr_type;
    logic [8:0]  queue_arith_instr;
    logic [2:0]  queue_ram_instr;
    logic [6:0]  queue_ld_st_instr;
    logic [17:0] cache_addr;
    logic [17:0] main_mem_addr;
    logic        program_complete;
    logic        queue_full;
    logic [3:0]  queue_count;
    logic        ram_valid, ram_ready, ldst_valid, ldst_ready, arith_valid, arith_ready;
    logic [2:0]  ram_instr;
    logic [17:0] ram_cache_addr, ram_main_mem_addr, ldst_cache_addr;
    logic [6:0]  ldst_instr;
    logic [8:0]  arith_instr;
    logic        all_done, dispatch_error;
    logic [15:0] ram_stall_cnt, ldst_stall_cnt, arith_stall_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    instr_dispatch #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .queue_we(queue_we), .queue_instr_type(queue_instr_type),
        .queue_arith_instr(queue_arith_instr), .queue_ram_instr(queue_ram_instr),
        .queue_ld_st_instr(queue_ld_st_instr), .cache_addr(cache_addr),
        .main_mem_addr(main_mem_addr), .program_complete(program_complete),
        .queue_full(queue_full), .queue_count(queue_count),
        .ram_valid(ram_valid), .ram_ready(ram_ready), .ram_instr(ram_instr),
        .ram_cache_addr(ram_cache_addr), .ram_main_mem_addr(ram_main_mem_addr),
        .ldst_valid(ldst_valid), .ldst_ready(ldst_ready), .ldst_instr(ldst_instr),
        .ldst_cache_addr(ldst_cache_addr), .arith_valid(arith_valid),
        .arith_ready(arith_ready), .arith_instr(arith_instr), .all_done(all_done),
        .dispatch_error(dispatch_error), .ram_stall_cnt(ram_stall_cnt),
        .ldst_stall_cnt(ldst_stall_cnt), .arith_stall_cnt(arith_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  typ;
        logic [8:0]  a;
        logic [2:0]  r;
        logic [6:0]  l;
        logic [17:0] c;
        logic [17:0] m;
        logic [2:0]  rdy;    // {ram, ldst, arith}
        logic [2:0]  e_v;    // {ram, ldst, arith}
        logic [3:0]  e_cnt;
        logic        e_err;
        logic [18:0] e_pay;  // {ram_instr, ldst_instr, arith_instr}
        logic [53:0] e_adr;  // {ram_cache, ram_main, ldst_cache}
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];
    logic [8:0] q [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] valids();
        return {ram_valid, ldst_valid, arith_valid};
    endfunction
    function automatic logic [18:0] pay();
        return {ram_instr, ldst_instr, arith_instr};
    endfunction
    function automatic logic [53:0] adr();
        return {ram_cache_addr, ram_main_mem_addr, ldst_cache_addr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        queue_we = 1'b0; queue_instr_type = 2'd0; queue_arith_instr = 9'd0;
        queue_ram_instr = 3'd0; queue_ld_st_instr = 7'd0; cache_addr = 18'd0;
        main_mem_addr = 18'd0; program_complete = 1'b0;
        {ram_ready, ldst_ready, arith_ready} = 3'b000;
    endtask

    task automatic push_in(input logic [1:0] t, input logic [8:0] a, input logic [2:0] r,
                           input logic [6:0] l, input logic [17:0] c, input logic [17:0] m);
        queue_we = 1'b1; queue_instr_type = t; queue_arith_instr = a;
        queue_ram_instr = r; queue_ld_st_instr = l; cache_addr = c; main_mem_addr = m;
    endtask

    task automatic do_reset();
        clr();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1'b0, T_R, 9'h0,   3'd0, 7'h0,  18'h0,  18'h0,  3'b000, 3'b000, 4'd0, 1'b0, 19'd0, 54'd0};
        vt[1]  = '{1'b1, T_R, 9'h0,   3'd5, 7'h0,  18'h2,  18'h3,  3'b100, 3'b100, 4'd1, 1'b0, {3'd5, 16'd0}, {18'h2, 18'h3, 18'h0}};
        vt[2]  = '{1'b0, T_R, 9'h0,   3'd0, 7'h0,  18'h0,  18'h0,  3'b100, 3'b000, 4'd0, 1'b0, 19'd0, 54'd0};
        vt[3]  = '{1'b1, T_R, 9'h0,   3'd3, 7'h0,  18'h10, 18'h11, 3'b000, 3'b100, 4'd1, 1'b0, {3'd3, 16'd0}, {18'h10, 18'h11, 18'h0}};
        vt[4]  = '{1'b1, T_L, 9'h0,   3'd0, 7'h55, 18'h20, 18'h0,  3'b000, 3'b100, 4'd2, 1'b0, {3'd3, 16'd0}, {18'h10, 18'h11, 18'h0}};
        vt[5]  = '{1'b1, T_A, 9'h1A5, 3'd0, 7'h0,  18'h0,  18'h0,  3'b000, 3'b100, 4'd3, 1'b0, {3'd3, 16'd0}, {18'h10, 18'h11, 18'h0}};
        vt[6]  = '{1'b1, T_L, 9'h0,   3'd0, 7'h2A, 18'h30, 18'h0,  3'b000, 3'b100, 4'd4, 1'b0, {3'd3, 16'd0}, {18'h10, 18'h11, 18'h0}};
        vt[7]  = '{1'b1, T_R, 9'h0,   3'd6, 7'h0,  18'h40, 18'h41, 3'b000, 3'b100, 4'd5, 1'b0, {3'd3, 16'd0}, {18'h10, 18'h11, 18'h0}};
        vt[8]  = '{1'b0, T_R, 9'h0,   3'd0, 7'h0,  18'h0,  18'h0,  3'b011, 3'b100, 4'd5, 1'b0, {3'd3, 16'd0}, {18'h10, 18'h11, 18'h0}};
        vt[9]  = '{1'b0, T_R, 9'h0,   3'd0, 7'h0,  18'h0,  18'h0,  3'b100, 3'b010, 4'd4, 1'b0, {3'd0, 7'h55, 9'h0}, {36'h0, 18'h20}};
        vt[10] = '{1'b0, T_R, 9'h0,   3'd0, 7'h0,  18'h0,  18'h0,  3'b101, 3'b010, 4'd4, 1'b0, {3'd0, 7'h55, 9'h0}, {36'h0, 18'h20}};
        vt[11] = '{1'b0, T_R, 9'h0,   3'd0, 7'h0,  18'h0,  18'h0,  3'b010, 3'b001, 4'd3, 1'b0, {10'h0, 9'h1A5}, 54'd0};
        vt[12] = '{1'b0, T_R, 9'h0,   3'd0, 7'h0,  18'h0,  18'h0,  3'b001, 3'b010, 4'd2, 1'b0, {3'd0, 7'h2A, 9'h0}, {36'h0, 18'h30}};
        vt[13] = '{1'b0, T_R, 9'h0,   3'd0, 7'h0,  18'h0,  18'h0,  3'b010, 3'b100, 4'd1, 1'b0, {3'd6, 16'd0}, {18'h40, 18'h41, 18'h0}};
        vt[14] = '{1'b0, T_R, 9'h0,   3'd0, 7'h0,  18'h0,  18'h0,  3'b100, 3'b000, 4'd0, 1'b0, 19'd0, 54'd0};
        vt[15] = '{1'b1, T_P, 9'h1FF, 3'd7, 7'h7F, 18'h5,  18'h5,  3'b000, 3'b000, 4'd0, 1'b1, 19'd0, 54'd0};
        vt[16] = '{1'b1, T_R, 9'h0,   3'd1, 7'h0,  18'h1,  18'h1,  3'b000, 3'b100, 4'd1, 1'b1, {3'd1, 16'd0}, {18'h1, 18'h1, 18'h0}};

        // Reset state
        do_reset();
        chk("rst_valids", 64'(valids()), 64'd0);
        chk("rst_count", 64'(queue_count), 64'd0);
        chk("rst_flags", 64'({queue_full, all_done, dispatch_error}), 64'd0);
        chk("rst_stall", 64'({ram_stall_cnt, ldst_stall_cnt, arith_stall_cnt}), 64'd0);
        chk("rst_pay", 64'(pay()), 64'd0);
        chk("rst_adr", 64'(adr()), 64'd0);

        // Vector table: single RAM issue, in-order mixed issue, ignored readies, LOOP reject
        for (int i = 0; i < NV; i++) begin
            queue_we = vt[i].we; queue_instr_type = vt[i].typ; queue_arith_instr = vt[i].a;
            queue_ram_instr = vt[i].r; queue_ld_st_instr = vt[i].l;
            cache_addr = vt[i].c; main_mem_addr = vt[i].m; program_complete = 1'b0;
            {ram_ready, ldst_ready, arith_ready} = vt[i].rdy;
            tick();
            chk($sformatf("v%0d_valids", i), 64'(valids()), 64'(vt[i].e_v));
            chk($sformatf("v%0d_count", i), 64'(queue_count), 64'(vt[i].e_cnt));
            chk($sformatf("v%0d_err", i), 64'(dispatch_error), 64'(vt[i].e_err));
            chk($sformatf("v%0d_pay", i), 64'(pay()), 64'(vt[i].e_pay));
            chk($sformatf("v%0d_adr", i), 64'(adr()), 64'(vt[i].e_adr));
        end
        clr();

        // Asynchronous reset mid-operation discards queued entries
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_in(T_R, 9'd0, 3'(i + 1), 7'd0, 18'(i), 18'(i));
            tick();
        end
        clr();
        chk("mid_pre_count", 64'(queue_count), 64'd3);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_count", 64'(queue_count), 64'd0);
        chk("mid_rst_valids", 64'(valids()), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("mid_post_count", 64'(queue_count), 64'd0);

        // Fill to full, overflow drop, push+pop while full, wrap at count 7
        do_reset();
        q.delete();
        for (int i = 1; i <= 9; i++) begin
            push_in(T_A, 9'(i), 3'd0, 7'd0, 18'd0, 18'd0);
            tick();
            if (i <= DEPTH) q.push_back(9'(i));
            if (i == 7) chk("fill7_full", 64'({queue_full, queue_count}), 64'({1'b0, 4'd7}));
            if (i == 8) chk("fill8_full", 64'({queue_full, queue_count, dispatch_error}), 64'({1'b1, 4'd8, 1'b0}));
        end
        chk("fill9_state", 64'({queue_full, queue_count, dispatch_error}), 64'({1'b1, 4'd8, 1'b1}));
        chk("fill9_head", 64'(arith_instr), 64'(q[0]));
        push_in(T_A, 9'd100, 3'd0, 7'd0, 18'd0, 18'd0);
        arith_ready = 1'b1;
        tick();
        void'(q.pop_front());
        chk("fullpp_count", 64'({queue_full, queue_count}), 64'({1'b0, 4'd7}));
        chk("fullpp_head", 64'(arith_instr), 64'(q[0]));
        for (int k = 0; k < 20; k++) begin
            push_in(T_A, 9'(200 + k), 3'd0, 7'd0, 18'd0, 18'd0);
            arith_ready = 1'b1;
            tick();
            void'(q.pop_front());
            q.push_back(9'(200 + k));
            chk($sformatf("wrap%0d_count", k), 64'(queue_count), 64'd7);
            chk($sformatf("wrap%0d_head", k), 64'(arith_instr), 64'(q[0]));
        end
        clr();
        arith_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("drain%0d_head", k), 64'(arith_instr), 64'(q[0]));
            tick();
            void'(q.pop_front());
            chk($sformatf("drain%0d_count", k), 64'(queue_count), 64'(6 - k));
        end
        chk("drain_valids", 64'(valids()), 64'd0);
        clr();

        // program_complete on empty queue: all_done two cycles later; push clears it
        do_reset();
        program_complete = 1'b1;
        tick();
        program_complete = 1'b0;
        chk("pc_empty_c1", 64'(all_done), 64'd0);
        tick();
        chk("pc_empty_c2", 64'(all_done), 64'd1);
        push_in(T_R, 9'd0, 3'd2, 7'd0, 18'd7, 18'd8);
        tick();
        clr();
        chk("done_push_clr", 64'({all_done, ram_valid}), 64'({1'b0, 1'b1}));
        tick();
        chk("run_stays", 64'(all_done), 64'd0);

        // Drain with entries, including a push accepted during DRAIN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_in(T_L, 9'd0, 3'd0, 7'(i + 1), 18'(i), 18'd0);
            tick();
        end
        clr();
        program_complete = 1'b1;
        tick();
        program_complete = 1'b0;
        chk("drain_entry", 64'({all_done, queue_count}), 64'({1'b0, 4'd3}));
        push_in(T_R, 9'd0, 3'd4, 7'd0, 18'd9, 18'd9);
        {ram_ready, ldst_ready, arith_ready} = 3'b111;
        tick();
        queue_we = 1'b0;
        chk("drain_pushpop", 64'({all_done, queue_count}), 64'({1'b0, 4'd3}));
        for (int k = 2; k >= 0; k--) begin
            tick();
            chk($sformatf("drain_pop_c%0d", k), 64'({all_done, queue_count}), 64'({k == 0, 4'(k)}));
        end
        clr();
        push_in(T_A, 9'd1, 3'd0, 7'd0, 18'd0, 18'd0);
        tick();
        clr();
        chk("drain_repush", 64'({all_done, queue_count}), 64'({1'b0, 4'd1}));

        // Stall counter on a held arithmetic head
        do_reset();
        push_in(T_A, 9'h33, 3'd0, 7'd0, 18'd0, 18'd0);
        tick();
        clr();
        repeat (5) tick();
        chk("stall_arith", 64'(arith_stall_cnt), 64'(STALL_EXP));
        chk("stall_others", 64'({ram_stall_cnt, ldst_stall_cnt}), 64'd0);
        arith_ready = 1'b1;
        tick();
        clr();
        chk("stall_pop_count", 64'(queue_count), 64'd0);
        chk("stall_hold", 64'(arith_stall_cnt), 64'(STALL_EXP));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
